zmaps_buf: RTL and testbench



---
 rtl/zmaps_pkg.sv | 21 ++
 rtl/zmaps_fifo.sv | 60 ++++++
 rtl/zmaps_buf.sv | 125 ++++++++++++
 tb/tb_zmaps_buf.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zmaps_pkg.sv
// Shared constants and sizing helpers for the Z80-to-FPRAM write mapper.
//   FILE_CRAM / FILE_SFYS : file indices of the colour RAM and sprite file
//   REGS_SEL              : a[11:8] value that selects the byte-wide register file
//   sel_width()           : bits needed to carry a file index (at least 1)
//   entry_width()         : width of one queued CPU word write {sel, addr, data}
package zmaps_pkg;

    localparam int unsigned FILE_CRAM = 0;
    localparam int unsigned FILE_SFYS = 1;
    localparam logic [3:0]  REGS_SEL  = 4'b0100;

    function automatic int unsigned sel_width(input int unsigned files);
        return (files > 1) ? $clog2(files) : 1;
    endfunction

    function automatic int unsigned entry_width(input int unsigned files,
                                                input int unsigned aw);
        return sel_width(files) + aw + 16;
    endfunction

endpackage

// File: rtl/zmaps_fifo.sv
// Synchronous show-ahead FIFO. The head entry is visible whenever the FIFO is
// not empty and is consumed by pop at the clock edge.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; accepted when not full or when a
//                   pop happens in the same cycle
//   pop           : remove head entry (ignored when empty)
//   head          : current head entry
//   cnt           : number of stored entries, 0..DEPTH
//   full, empty   : status flags
module zmaps_fifo #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    cnt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push on full is still accepted.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/zmaps_buf.sv
// Buffered Z80-to-FPRAM write mapper. Decodes Z80 writes in the 4 KB window,
// pairs an even-address byte (lsb) with the following odd-address byte into a
// word, queues word writes and arbitrates them against DMA (DMA first).
//   clk, rst            : clock, synchronous active-high reset
//   memwr_s, a, d       : Z80 write strobe, address, data
//   fmaddr              : [4] window enable, [3:0] window base a[15:12]
//   dma_data/wraddr/we  : DMA write word, word address, per-file request
//   zma, zmd, file_we   : file word address, write word, one-hot file strobe
//   regs_we/a/d         : register-file byte write (combinational)
//   fifo_cnt            : queued CPU word writes
//   ovf, ovf_clr        : sticky lost-write flag and its clear
module zmaps_buf
    import zmaps_pkg::*;
#(
    parameter int unsigned  FILES = 2,
    parameter int unsigned  AW    = 8,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned SW    = sel_width(FILES),
    localparam int unsigned EW    = entry_width(FILES, AW),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memwr_s,
    input  logic [15:0]      a,
    input  logic [7:0]       d,
    input  logic [4:0]       fmaddr,
    input  logic [15:0]      dma_data,
    input  logic [AW-1:0]    dma_wraddr,
    input  logic [FILES-1:0] dma_we,
    output logic [AW-1:0]    zma,
    output logic [15:0]      zmd,
    output logic [FILES-1:0] file_we,
    output logic             regs_we,
    output logic [7:0]       regs_a,
    output logic [7:0]       regs_d,
    output logic [CW-1:0]    fifo_cnt,
    output logic             ovf,
    input  logic             ovf_clr
);

    logic          hit;
    logic          file_ok;
    logic          push_req;
    logic          pop;
    logic          dma_any;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    lsb_q;
    logic          ovf_q;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic [SW-1:0] head_sel;
    logic [AW-1:0] head_addr;
    logic [15:0]   head_data;

    assign hit     = memwr_s & fmaddr[4] & (a[15:12] == fmaddr[3:0]);
    assign file_ok = (32'(a[11:9]) < FILES);
    assign push_req   = ~rst & hit & a[0] & file_ok;
    assign push_entry = {SW'(a[11:9]), a[AW:1], d, lsb_q};

    assign dma_any = |dma_we;
    assign pop     = ~rst & ~dma_any & ~fifo_empty;

    assign {head_sel, head_addr, head_data} = head;

    // Register path bypasses the FIFO and DMA arbitration entirely.
    assign regs_we = ~rst & hit & (a[11:8] == REGS_SEL);
    assign regs_a  = a[7:0];
    assign regs_d  = d;

    zmaps_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // lsb survives the word push so repeated odd writes reuse the same low byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_q <= 8'h00;
        end else if (hit && !a[0]) begin
            lsb_q <= d;
        end
    end

    // Set wins over clear when an overflow coincides with ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;

    always_comb begin
        file_we = '0;
        zma     = head_addr;
        zmd     = head_data;
        if (!rst) begin
            if (dma_any) begin
                // Isolate the lowest set request bit.
                file_we = dma_we & (~dma_we + FILES'(1));
                zma     = dma_wraddr;
                zmd     = dma_data;
            end else if (!fifo_empty) begin
                file_we = FILES'(1) << head_sel;
            end
        end
    end

endmodule

// File: tb/tb_zmaps_buf.sv
module tb_zmaps_buf;

    localparam int unsigned FILES = 2;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             memwr_s;
    logic [15:0]      a;
    logic [7:0]       d;
    logic [4:0]       fmaddr;
    logic [15:0]      dma_data;
    logic [AW-1:0]    dma_wraddr;
    logic [FILES-1:0] dma_we;
    logic [AW-1:0]    zma;
    logic [15:0]      zmd;
    logic [FILES-1:0] file_we;
    logic             regs_we;
    logic [7:0]       regs_a;
    logic [7:0]       regs_d;
    logic [CW-1:0]    fifo_cnt;
    logic             ovf;
    logic             ovf_clr;

    zmaps_buf #(
        .FILES (FILES),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memwr_s    (memwr_s),
        .a          (a),
        .d          (d),
        .fmaddr     (fmaddr),
        .dma_data   (dma_data),
        .dma_wraddr (dma_wraddr),
        .dma_we     (dma_we),
        .zma        (zma),
        .zmd        (zmd),
        .file_we    (file_we),
        .regs_we    (regs_we),
        .regs_a     (regs_a),
        .regs_d     (regs_d),
        .fifo_cnt   (fifo_cnt),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending CPU word writes in delivery order.
    typedef struct {
        int          sel;
        int          addr;
        logic [15:0] data;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_lsb;
    bit         m_ovf;
    int         n_vec;
    int         n_err;

    // Check all outputs against the model for the inputs currently applied.
    task automatic sample();
        int exp_we, exp_zma, exp_zmd;
        bit hit, exp_regs;
        @(negedge clk);
        hit = memwr_s && fmaddr[4] && (a[15:12] == fmaddr[3:0]);
        exp_we = 0; exp_zma = 0; exp_zmd = 0;
        if (!rst) begin
            if (dma_we != 0) begin
                for (int j = FILES - 1; j >= 0; j--) if (dma_we[j]) exp_we = 1 << j;
                exp_zma = int'(dma_wraddr);
                exp_zmd = int'(dma_data);
            end else if (mq.size() > 0) begin
                exp_we  = 1 << mq[0].sel;
                exp_zma = mq[0].addr;
                exp_zmd = int'(mq[0].data);
            end
        end
        exp_regs = !rst && hit && (a[11:8] == 4'h4);
        n_vec++;
        if (file_we !== FILES'(exp_we)) begin
            n_err++; $display("FAIL file_we: got %b want %b @%0t", file_we, FILES'(exp_we), $time);
        end
        if (exp_we != 0) begin
            n_vec++;
            if (zma !== AW'(exp_zma) || zmd !== 16'(exp_zmd)) begin
                n_err++;
                $display("FAIL zma/zmd: got %h/%h want %h/%h @%0t", zma, zmd, AW'(exp_zma),
                         16'(exp_zmd), $time);
            end
        end
        n_vec++;
        if (regs_we !== exp_regs) begin
            n_err++; $display("FAIL regs_we: got %b want %b @%0t", regs_we, exp_regs, $time);
        end
        if (exp_regs) begin
            n_vec++;
            if (regs_a !== a[7:0] || regs_d !== d) begin
                n_err++;
                $display("FAIL regs_a/d: got %h/%h want %h/%h @%0t", regs_a, regs_d, a[7:0], d,
                         $time);
            end
        end
        n_vec++;
        if (fifo_cnt !== CW'(mq.size()) || ovf !== m_ovf) begin
            n_err++;
            $display("FAIL cnt/ovf: got %0d/%b want %0d/%b @%0t", fifo_cnt, ovf, mq.size(), m_ovf,
                     $time);
        end
    endtask

    // Apply the clock edge to the model, then release the inputs for the next cycle.
    task automatic advance();
        bit hit, push, pop, full;
        @(posedge clk);
        hit = memwr_s && fmaddr[4] && (a[15:12] == fmaddr[3:0]);
        if (rst) begin
            mq.delete();
            m_lsb = 8'h00;
            m_ovf = 1'b0;
        end else begin
            full = (mq.size() == DEPTH);
            pop  = (dma_we == 0) && (mq.size() > 0);
            push = hit && a[0] && (int'(a[11:9]) < FILES);
            if (pop) void'(mq.pop_front());
            if (push && full && !pop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (push && (!full || pop)) mq.push_back('{int'(a[11:9]), int'(a[AW:1]), {d, m_lsb}});
            if (hit && !a[0]) m_lsb = d;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle();
        memwr_s = 1'b0; dma_we = '0; ovf_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
        memwr_s = 1'b1; a = addr; d = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        advance();
        sample();
        n_vec++;
        if (fifo_cnt !== '0 || ovf !== 1'b0 || file_we !== '0) begin
            n_err++; $display("FAIL reset_state: got cnt=%0d ovf=%b we=%b want 0/0/0",
                              fifo_cnt, ovf, file_we);
        end
        advance();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        fmaddr = 5'h1F;
        cpu_wr(16'hF000, 8'h34); cyc();
        cpu_wr(16'hF001, 8'h12); cyc();
        memwr_s = 1'b0;
        sample();
        n_vec++;
        if (file_we !== 2'b01 || zma !== 8'h00 || zmd !== 16'h1234) begin
            n_err++; $display("FAIL basic_word: got we=%b zma=%h zmd=%h want 01/00/1234",
                              file_we, zma, zmd);
        end
        advance();
        sample();
        n_vec++;
        if (fifo_cnt !== '0) begin
            n_err++; $display("FAIL basic_drain: got cnt=%0d want 0", fifo_cnt);
        end
        advance();
    endtask

    task automatic test_dma_delay();
        dma_we = 2'b10; dma_wraddr = 8'hA5; dma_data = 16'hBEEF;
        cpu_wr(16'hF001, 8'h12);
        for (int i = 0; i < 3; i++) begin
            sample();
            n_vec++;
            if (file_we !== 2'b10 || zma !== 8'hA5 || zmd !== 16'hBEEF) begin
                n_err++; $display("FAIL dma_strobe%0d: got we=%b zma=%h zmd=%h want 10/a5/beef",
                                  i, file_we, zma, zmd);
            end
            advance();
            memwr_s = 1'b0;
        end
        dma_we = '0;
        sample();
        n_vec++;
        if (file_we !== 2'b01 || zmd !== 16'h1234) begin
            n_err++; $display("FAIL dma_then_cpu: got we=%b zmd=%h want 01/1234", file_we, zmd);
        end
        advance();
        cyc();
    endtask

    task automatic test_overflow();
        dma_we = 2'b01; dma_wraddr = 8'h3C; dma_data = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            cpu_wr(16'hF201 + 16'(2 * i), 8'(i + 1));
            cyc();
        end
        memwr_s = 1'b0;
        sample();
        n_vec++;
        if (fifo_cnt !== CW'(4) || ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_full: got cnt=%0d ovf=%b want 4/1", fifo_cnt, ovf);
        end
        advance();
        dma_we = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            n_vec++;
            if (file_we !== 2'b10 || zma !== AW'(i) || zmd[15:8] !== 8'(i + 1)) begin
                n_err++; $display("FAIL ovf_order%0d: got we=%b zma=%h msb=%h want 10/%h/%h",
                                  i, file_we, zma, zmd[15:8], AW'(i), 8'(i + 1));
            end
            advance();
        end
        cyc();
        ovf_clr = 1'b1; cyc();
        ovf_clr = 1'b0;
        sample();
        n_vec++;
        if (ovf !== 1'b0 || file_we !== '0) begin
            n_err++; $display("FAIL ovf_clear: got ovf=%b we=%b want 0/00", ovf, file_we);
        end
        advance();
    endtask

    task automatic test_regs();
        dma_we = 2'b11; dma_wraddr = 8'h11; dma_data = 16'h2222;
        cpu_wr(16'hF400, 8'h5A);
        sample();
        n_vec++;
        if (regs_we !== 1'b1 || regs_a !== 8'h00 || regs_d !== 8'h5A || file_we !== 2'b01) begin
            n_err++; $display("FAIL regs_dma: got rwe=%b ra=%h rd=%h we=%b want 1/00/5a/01",
                              regs_we, regs_a, regs_d, file_we);
        end
        advance();
        fmaddr = 5'h0F;
        sample();
        n_vec++;
        if (regs_we !== 1'b0) begin
            n_err++; $display("FAIL regs_disabled: got rwe=%b want 0", regs_we);
        end
        advance();
        fmaddr = 5'h1F;
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        dma_we = 2'b01;
        for (int i = 0; i < 5; i++) begin
            cpu_wr(16'hF005 + 16'(2 * i), 8'hC0 + 8'(i));
            cyc();
        end
        memwr_s = 1'b0; dma_we = '0; rst = 1'b1;
        sample();
        n_vec++;
        if (file_we !== '0) begin
            n_err++; $display("FAIL rst_no_strobe: got we=%b want 00", file_we);
        end
        advance();
        rst = 1'b0;
        sample();
        n_vec++;
        if (fifo_cnt !== '0 || ovf !== 1'b0 || file_we !== '0) begin
            n_err++; $display("FAIL rst_mid_state: got cnt=%0d ovf=%b we=%b want 0/0/00",
                              fifo_cnt, ovf, file_we);
        end
        advance();
        cpu_wr(16'hF003, 8'h77); cyc();
        memwr_s = 1'b0;
        sample();
        n_vec++;
        if (file_we !== 2'b01 || zma !== 8'h01 || zmd !== 16'h7700) begin
            n_err++; $display("FAIL rst_lsb: got we=%b zma=%h zmd=%h want 01/01/7700",
                              file_we, zma, zmd);
        end
        advance();
    endtask

    task automatic test_random();
        logic [3:0] hi;
        for (int i = 0; i < 600; i++) begin
            hi         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            memwr_s    = 1'($urandom_range(0, 1));
            a          = {hi, 4'($urandom_range(0, 5)), 8'($urandom)};
            d          = 8'($urandom);
            dma_we     = ($urandom_range(0, 2) == 0) ? FILES'($urandom) : '0;
            dma_wraddr = AW'($urandom);
            dma_data   = 16'($urandom);
            ovf_clr    = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            fmaddr     = ($urandom_range(0, 19) == 0) ? 5'($urandom) : 5'h1F;
            cyc();
        end
        idle();
        fmaddr = 5'h1F;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        mq.delete(); m_lsb = 8'h00; m_ovf = 1'b0;
        rst = 1'b1; memwr_s = 1'b0; a = '0; d = '0; fmaddr = 5'h1F;
        dma_data = '0; dma_wraddr = '0; dma_we = '0; ovf_clr = 1'b0;
        test_reset();
        test_basic();
        test_dma_delay();
        test_overflow();
        test_regs();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
